// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-granular two-port arbiter in front of the TX AXIS path.
// Frames from two sources are never interleaved. The per-frame TX response is
// routed back to the source that sent the frame, using an in-order FIFO of port IDs.
module tx_frame_arbiter #(
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int PRIO_EN           = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] s0_tdata_i,
    input  logic [1:0]  s0_tvldb_i,
    input  logic        s0_tvalid_i,
    output logic        s0_tready_o,
    input  logic        s0_tlast_i,
    input  logic        s0_tuser_i,
    output logic        s0_status_o,
    output logic        s0_rsp_valid_o,

    input  logic [31:0] s1_tdata_i,
    input  logic [1:0]  s1_tvldb_i,
    input  logic        s1_tvalid_i,
    output logic        s1_tready_o,
    input  logic        s1_tlast_i,
    input  logic        s1_tuser_i,
    output logic        s1_status_o,
    output logic        s1_rsp_valid_o,

    output logic [31:0] m_tdata_o,
    output logic [1:0]  m_tvldb_o,
    output logic        m_tvalid_o,
    output logic        m_tlast_o,
    output logic        m_tuser_o,
    input  logic        m_tready_i,

    input  logic        tx_status_i,
    input  logic        tx_rsp_valid_i,

    output logic [1:0]  grant_o,
    output logic        orphan_err_o
);

    localparam int PTR_W = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last_grant;
    logic               r_fifo_mem [OUTSTANDING_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_rsp_valid;
    logic [1:0]         r_status;
    logic               r_orphan;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_push_id;
    logic               w_pop;
    logic               w_head;
    logic               w_take;
    logic               w_winner;

    assign w_full    = (r_count == CNT_W'(OUTSTANDING_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = m_tvalid_o & m_tready_i & m_tlast_o;
    assign w_push_id = (r_state == ST_GRANT1);
    assign w_pop     = tx_rsp_valid_i & ~w_empty;
    assign w_head    = r_fifo_mem[r_rd_ptr];

    // Grant is only taken from IDLE, and only while a slot is free for the frame's ID.
    assign w_take    = (r_state == ST_IDLE) & ~w_full & (s0_tvalid_i | s1_tvalid_i);

    // Priority mode favours port 1; round-robin breaks ties against the last winner.
    assign w_winner  = (PRIO_EN != 0) ? s1_tvalid_i
                     : ((s0_tvalid_i & s1_tvalid_i) ? ~r_last_grant : s1_tvalid_i);

    assign grant_o   = {r_state == ST_GRANT1, r_state == ST_GRANT0};

    // Combinational data mux steered by the registered state (zero added latency).
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        m_tdata_o   = '0;
        m_tvldb_o   = '0;
        m_tvalid_o  = 1'b0;
        m_tlast_o   = 1'b0;
        m_tuser_o   = 1'b0;
        s0_tready_o = 1'b0;
        s1_tready_o = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                m_tdata_o   = s0_tdata_i;
                m_tvldb_o   = s0_tvldb_i;
                m_tvalid_o  = s0_tvalid_i;
                m_tlast_o   = s0_tlast_i;
                m_tuser_o   = s0_tuser_i;
                s0_tready_o = m_tready_i;
            end
            ST_GRANT1: begin
                m_tdata_o   = s1_tdata_i;
                m_tvldb_o   = s1_tvldb_i;
                m_tvalid_o  = s1_tvalid_i;
                m_tlast_o   = s1_tlast_i;
                m_tuser_o   = s1_tuser_i;
                s1_tready_o = m_tready_i;
            end
            default: ;
        endcase
    end

    // Arbitration FSM: grant held until the frame's tlast beat is accepted.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep all state updates on the same edge.
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state      <= w_winner ? ST_GRANT1 : ST_GRANT0;
                        r_last_grant <= w_winner;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (w_push) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Port-ID storage; contents are only meaningful below the count.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; r_count marks valid entries.
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_push_id;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Route each TX response to the head port one cycle later; flag responses with no owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= '0;
            r_status    <= '0;
            r_orphan    <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_status    <= '0;
            if (w_pop) begin
                r_rsp_valid[w_head] <= 1'b1;
                r_status[w_head]    <= tx_status_i;
            end
            if (tx_rsp_valid_i && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    assign s0_rsp_valid_o = r_rsp_valid[0];
    assign s1_rsp_valid_o = r_rsp_valid[1];
    assign s0_status_o    = r_status[0];
    assign s1_status_o    = r_status[1];
    assign orphan_err_o   = r_orphan;

endmodule
